// File: rtl/mips_debug_pkg.sv
// rtl/mips_debug_pkg.sv - host command bytes, FSM state encoding and dump size for the debug controller
package mips_debug_pkg;

    localparam logic [7:0] CMD_LOAD  = 8'h4C;
    localparam logic [7:0] CMD_RESET = 8'h43;
    localparam logic [7:0] CMD_RUN   = 8'h52;
    localparam logic [7:0] CMD_STEP  = 8'h53;
    localparam logic [7:0] CMD_DUMP  = 8'h44;
    localparam logic [7:0] ACK_BYTE  = 8'h4B;

    // PC followed by r0..r31
    localparam int DUMP_WORDS = 33;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD_CNT,
        ST_LOAD_BYTE,
        ST_LOAD_WR,
        ST_ACK,
        ST_CPU_RST,
        ST_RUN,
        ST_STEP,
        ST_DUMP_LD,
        ST_DUMP_RD,
        ST_DUMP_TX,
        ST_DUMP_WAIT
    } state_t;

endpackage

// File: rtl/debug_word_tx.sv
// rtl/debug_word_tx.sv - sends one word MSB-first (or only its top byte) over a start/done byte transmitter
module debug_word_tx #(
    parameter int NB_DATA = 32,
    parameter int NB_BYTE = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_single,
    input  logic [NB_DATA-1:0] i_word,
    input  logic               i_tx_done,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_done
);

    logic [NB_DATA-1:0] r_shift;
    logic [1:0]         r_left;
    logic               r_busy;

    // A done strobe in the same cycle as o_tx_start belongs to the previous byte and is ignored.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_shift    <= '0;
            r_left     <= '0;
            r_busy     <= 1'b0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            o_tx_start <= 1'b0;
            o_done     <= 1'b0;
            if (i_start && !r_busy) begin
                r_busy     <= 1'b1;
                o_tx_start <= 1'b1;
                o_tx_data  <= i_word[NB_DATA-1 -: NB_BYTE];
                r_shift    <= {i_word[NB_DATA-NB_BYTE-1:0], {NB_BYTE{1'b0}}};
                r_left     <= i_single ? 2'd0 : 2'd3;
            end else if (r_busy && !o_tx_start && i_tx_done) begin
                if (r_left == 2'd0) begin
                    r_busy <= 1'b0;
                    o_done <= 1'b1;
                end else begin
                    o_tx_start <= 1'b1;
                    o_tx_data  <= r_shift[NB_DATA-1 -: NB_BYTE];
                    r_shift    <= {r_shift[NB_DATA-NB_BYTE-1:0], {NB_BYTE{1'b0}}};
                    r_left     <= r_left - 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/mips_debug_controller.sv
// rtl/mips_debug_controller.sv - host command sequencer for program load, CPU reset/run/step and state dump
module mips_debug_controller
    import mips_debug_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 32,
    parameter int NB_REG  = 5,
    parameter int NB_BYTE = 8,
    parameter int N_REGS  = 32
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_BYTE-1:0] i_rx_data,
    input  logic               i_rx_valid,
    input  logic               i_tx_done,
    input  logic               i_halt,
    input  logic [NB_DATA-1:0] i_pc,
    input  logic [NB_DATA-1:0] i_reg_data,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_imem_write,
    output logic [NB_ADDR-1:0] o_imem_addr,
    output logic [NB_DATA-1:0] o_imem_data,
    output logic               o_cpu_enable,
    output logic               o_cpu_reset,
    output logic [NB_REG-1:0]  o_reg_addr,
    output logic               o_busy
);

    // Item 0 is the PC, item k is register k-1; the counter stops at the last item, never wrapping.
    localparam logic [5:0] LAST_ITEM = 6'(N_REGS < DUMP_WORDS ? N_REGS : DUMP_WORDS - 1);

    state_t                     r_state;
    logic [7:0]                 r_count;
    logic [7:0]                 r_wcnt;
    logic [1:0]                 r_byte_cnt;
    logic [5:0]                 r_item;
    logic [NB_DATA-1:0]         r_word;
    logic [NB_DATA-NB_BYTE-1:0] r_load_word;
    logic                       r_ack_sent;

    logic               w_ser_start;
    logic               w_ser_single;
    logic [NB_DATA-1:0] w_ser_word;
    logic               w_ser_done;

    assign w_ser_start  = (r_state == ST_DUMP_TX) || ((r_state == ST_ACK) && !r_ack_sent);
    assign w_ser_single = (r_state == ST_ACK);
    assign w_ser_word   = w_ser_single ? {ACK_BYTE, {(NB_DATA-NB_BYTE){1'b0}}} : r_word;

    debug_word_tx #(.NB_DATA(NB_DATA), .NB_BYTE(NB_BYTE)) u_word_tx (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_start    (w_ser_start),
        .i_single   (w_ser_single),
        .i_word     (w_ser_word),
        .i_tx_done  (i_tx_done),
        .o_tx_data  (o_tx_data),
        .o_tx_start (o_tx_start),
        .o_done     (w_ser_done)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_count      <= '0;
            r_wcnt       <= '0;
            r_byte_cnt   <= '0;
            r_item       <= '0;
            r_word       <= '0;
            r_load_word  <= '0;
            r_ack_sent   <= 1'b0;
            o_imem_write <= 1'b0;
            o_imem_addr  <= '0;
            o_imem_data  <= '0;
            o_cpu_enable <= 1'b0;
            o_cpu_reset  <= 1'b0;
            o_reg_addr   <= '0;
            o_busy       <= 1'b0;
        end else begin
            o_imem_write <= 1'b0;
            o_cpu_reset  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_item <= '0;
                    if (i_rx_valid) begin
                        case (i_rx_data)
                            CMD_LOAD: begin
                                o_busy  <= 1'b1;
                                r_state <= ST_LOAD_CNT;
                            end
                            CMD_RESET: begin
                                o_busy      <= 1'b1;
                                o_cpu_reset <= 1'b1;
                                r_state     <= ST_CPU_RST;
                            end
                            CMD_RUN: begin
                                o_busy <= 1'b1;
                                if (i_halt) begin
                                    r_state <= ST_DUMP_LD;
                                end else begin
                                    o_cpu_enable <= 1'b1;
                                    r_state      <= ST_RUN;
                                end
                            end
                            CMD_STEP: begin
                                o_busy       <= 1'b1;
                                o_cpu_enable <= 1'b1;
                                r_state      <= ST_STEP;
                            end
                            CMD_DUMP: begin
                                o_busy  <= 1'b1;
                                r_state <= ST_DUMP_LD;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_LOAD_CNT: begin
                    if (i_rx_valid) begin
                        r_count    <= i_rx_data;
                        r_wcnt     <= '0;
                        r_byte_cnt <= '0;
                        r_state    <= (i_rx_data == 8'd0) ? ST_ACK : ST_LOAD_BYTE;
                    end
                end
                ST_LOAD_BYTE: begin
                    if (i_rx_valid) begin
                        r_load_word <= {r_load_word[NB_DATA-2*NB_BYTE-1:0], i_rx_data};
                        r_byte_cnt  <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            o_imem_write <= 1'b1;
                            o_imem_addr  <= {{(NB_ADDR-8){1'b0}}, r_wcnt};
                            o_imem_data  <= {r_load_word, i_rx_data};
                            r_state      <= ST_LOAD_WR;
                        end
                    end
                end
                ST_LOAD_WR: begin
                    r_wcnt  <= r_wcnt + 8'd1;
                    r_state <= (r_wcnt == r_count - 8'd1) ? ST_ACK : ST_LOAD_BYTE;
                end
                ST_ACK: begin
                    if (w_ser_done) begin
                        r_ack_sent <= 1'b0;
                        o_busy     <= 1'b0;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_ack_sent <= 1'b1;
                    end
                end
                ST_CPU_RST: r_state <= ST_ACK;
                ST_RUN: begin
                    if (i_halt) begin
                        o_cpu_enable <= 1'b0;
                        r_state      <= ST_DUMP_LD;
                    end
                end
                ST_STEP: begin
                    o_cpu_enable <= 1'b0;
                    r_state      <= ST_DUMP_LD;
                end
                ST_DUMP_LD: begin
                    if (r_item == 6'd0) begin
                        r_word  <= i_pc;
                        r_state <= ST_DUMP_TX;
                    end else begin
                        o_reg_addr <= NB_REG'(r_item - 6'd1);
                        r_state    <= ST_DUMP_RD;
                    end
                end
                ST_DUMP_RD: begin
                    r_word  <= i_reg_data;
                    r_state <= ST_DUMP_TX;
                end
                ST_DUMP_TX: r_state <= ST_DUMP_WAIT;
                ST_DUMP_WAIT: begin
                    if (w_ser_done) begin
                        if (r_item == LAST_ITEM) begin
                            o_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_item  <= r_item + 6'd1;
                            r_state <= ST_DUMP_LD;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_debug_controller.sv
// tb/tb_mips_debug_controller.sv - directed bench for mips_debug_controller with a host/CPU model
module tb_mips_debug_controller;

    logic        clk;
    logic        i_reset;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic        i_tx_done;
    logic        i_halt;
    logic [31:0] i_pc;
    logic [31:0] i_reg_data;
    logic [7:0]  o_tx_data;
    logic        o_tx_start;
    logic        o_imem_write;
    logic [31:0] o_imem_addr;
    logic [31:0] o_imem_data;
    logic        o_cpu_enable;
    logic        o_cpu_reset;
    logic [4:0]  o_reg_addr;
    logic        o_busy;

    int n_cmp  = 0;
    int n_fail = 0;
    int en_cnt = 0;
    int rst_cnt = 0;
    int txs_cnt = 0;
    int wr_n = 0;
    logic [31:0] wr_addr [0:15];
    logic [31:0] wr_data [0:15];
    logic [7:0]  rx_buf [0:139];
    int rx_n;
    int base_en, base_rst, base_tx, wait_cyc;

    mips_debug_controller dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_rx_data    (i_rx_data),
        .i_rx_valid   (i_rx_valid),
        .i_tx_done    (i_tx_done),
        .i_halt       (i_halt),
        .i_pc         (i_pc),
        .i_reg_data   (i_reg_data),
        .o_tx_data    (o_tx_data),
        .o_tx_start   (o_tx_start),
        .o_imem_write (o_imem_write),
        .o_imem_addr  (o_imem_addr),
        .o_imem_data  (o_imem_data),
        .o_cpu_enable (o_cpu_enable),
        .o_cpu_reset  (o_cpu_reset),
        .o_reg_addr   (o_reg_addr),
        .o_busy       (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CPU model: PC = 4, r2 = 6, every other register 0
    assign i_pc       = 32'h4;
    assign i_reg_data = (o_reg_addr == 5'd2) ? 32'h6 : 32'h0;

    always @(negedge clk) begin
        en_cnt  <= en_cnt + int'(o_cpu_enable);
        rst_cnt <= rst_cnt + int'(o_cpu_reset);
        txs_cnt <= txs_cnt + int'(o_tx_start);
        if (o_imem_write && wr_n < 16) begin
            wr_addr[wr_n] <= o_imem_addr;
            wr_data[wr_n] <= o_imem_data;
            wr_n          <= wr_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk); #1;
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        @(negedge clk); #1;
        i_rx_valid = 1'b0;
    endtask

    // Host transmitter: answers each o_tx_start with a delayed done; optionally also
    // raises a done coincident with the first start and injects a command byte mid-dump.
    task automatic recv(input int n, input bit coinc, input bit inject);
        int w;
        rx_n = 0;
        for (int j = 0; j < n; j++) begin
            w = 0;
            while (o_tx_start !== 1'b1 && w < 300) begin
                @(negedge clk); #1;
                w++;
            end
            if (o_tx_start !== 1'b1) begin
                chk("tx_start_timeout", {31'b0, o_tx_start}, 32'h1);
                return;
            end
            rx_buf[j] = o_tx_data;
            rx_n++;
            if (coinc && j == 0) begin
                i_tx_done = 1'b1;
                @(negedge clk); #1;
                i_tx_done = 1'b0;
            end
            if (inject && j == 5) begin
                i_rx_data  = 8'h4C;
                i_rx_valid = 1'b1;
                @(negedge clk); #1;
                i_rx_valid = 1'b0;
            end
            @(negedge clk); #1;
            i_tx_done = 1'b1;
            @(negedge clk); #1;
            i_tx_done = 1'b0;
        end
    endtask

    task automatic check_dump(input string tag);
        int bad;
        logic [7:0] exp;
        bad = 0;
        for (int i = 0; i < rx_n; i++) begin
            exp = (i == 3) ? 8'h04 : (i == 15) ? 8'h06 : 8'h00;
            if (rx_buf[i] !== exp) bad++;
        end
        chk({tag, "_count"}, rx_n, 32'd132);
        chk({tag, "_bad_bytes"}, bad, 32'd0);
    endtask

    initial begin
        i_reset = 1'b1; i_rx_data = 8'h0; i_rx_valid = 1'b0; i_tx_done = 1'b0; i_halt = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_tx_data", o_tx_data, 32'h0);
        chk("rst_tx_start", o_tx_start, 32'h0);
        chk("rst_imem_write", o_imem_write, 32'h0);
        chk("rst_imem_addr", o_imem_addr, 32'h0);
        chk("rst_imem_data", o_imem_data, 32'h0);
        chk("rst_cpu_enable", o_cpu_enable, 32'h0);
        chk("rst_cpu_reset", o_cpu_reset, 32'h0);
        chk("rst_reg_addr", o_reg_addr, 32'h0);
        chk("rst_busy", o_busy, 32'h0);
        i_reset = 1'b0;

        // Load two words
        send_byte(8'h4C);
        chk("load_busy", o_busy, 32'h1);
        send_byte(8'h02);
        send_byte(8'h00); send_byte(8'h22); send_byte(8'h10); send_byte(8'h20);
        chk("load_w0_write", o_imem_write, 32'h1);
        chk("load_w0_addr", o_imem_addr, 32'h0);
        chk("load_w0_data", o_imem_data, 32'h00221020);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        chk("load_w1_write", o_imem_write, 32'h1);
        chk("load_w1_addr", o_imem_addr, 32'h1);
        chk("load_w1_data", o_imem_data, 32'h0);
        recv(1, 1'b0, 1'b0);
        chk("load_ack", rx_buf[0], 32'h4B);
        repeat (3) @(negedge clk);
        #1;
        chk("load_write_count", wr_n, 32'd2);
        chk("load_mon_w0", wr_data[0], 32'h00221020);
        chk("load_mon_a1", wr_addr[1], 32'h1);
        chk("load_idle", o_busy, 32'h0);

        // Zero-length load goes straight to ack
        send_byte(8'h4C);
        send_byte(8'h00);
        recv(1, 1'b0, 1'b0);
        chk("load0_ack", rx_buf[0], 32'h4B);
        chk("load0_no_write", wr_n, 32'd2);

        // CPU reset pulse
        base_rst = rst_cnt;
        send_byte(8'h43);
        chk("creset_pulse", o_cpu_reset, 32'h1);
        @(negedge clk); #1;
        chk("creset_pulse_end", o_cpu_reset, 32'h0);
        recv(1, 1'b0, 1'b0);
        chk("creset_ack", rx_buf[0], 32'h4B);
        chk("creset_count", rst_cnt - base_rst, 32'd1);

        // Step with coincident done on first byte and a command byte injected mid-dump
        base_en = en_cnt;
        base_tx = txs_cnt;
        send_byte(8'h53);
        chk("step_enable", o_cpu_enable, 32'h1);
        recv(132, 1'b1, 1'b1);
        check_dump("step");
        repeat (4) @(negedge clk);
        #1;
        chk("step_enable_cycles", en_cnt - base_en, 32'd1);
        chk("step_tx_starts", txs_cnt - base_tx, 32'd132);
        chk("step_idle", o_busy, 32'h0);
        chk("step_no_write", wr_n, 32'd2);

        // Unknown byte in IDLE is dropped
        base_en = en_cnt; base_tx = txs_cnt; base_rst = rst_cnt;
        send_byte(8'h7A);
        repeat (4) @(negedge clk);
        #1;
        chk("unk_busy", o_busy, 32'h0);
        chk("unk_tx", txs_cnt - base_tx, 32'd0);
        chk("unk_en", en_cnt - base_en, 32'd0);
        chk("unk_rst", rst_cnt - base_rst, 32'd0);
        chk("unk_write", wr_n, 32'd2);

        // Run until halt after 10 enable cycles
        base_en = en_cnt;
        send_byte(8'h52);
        wait_cyc = 0;
        while (en_cnt - base_en < 10 && wait_cyc < 100) begin
            @(negedge clk); #1;
            wait_cyc++;
        end
        i_halt = 1'b1;
        recv(132, 1'b0, 1'b0);
        i_halt = 1'b0;
        check_dump("run");
        chk("run_enable_cycles", en_cnt - base_en, 32'd10);

        // Run with halt already high: dump only
        i_halt = 1'b1;
        base_en = en_cnt;
        send_byte(8'h52);
        chk("runh_enable", o_cpu_enable, 32'h0);
        chk("runh_busy", o_busy, 32'h1);
        recv(132, 1'b0, 1'b0);
        i_halt = 1'b0;
        check_dump("runh");
        chk("runh_enable_cycles", en_cnt - base_en, 32'd0);

        // Reset held 2 cycles mid-run
        repeat (3) @(negedge clk);
        send_byte(8'h52);
        repeat (5) @(negedge clk);
        #1;
        chk("mid_run_enable", o_cpu_enable, 32'h1);
        i_reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        i_reset = 1'b0;
        chk("mid_rst_enable", o_cpu_enable, 32'h0);
        chk("mid_rst_busy", o_busy, 32'h0);
        send_byte(8'h43);
        chk("mid_rst_idle_cmd", o_cpu_reset, 32'h1);
        recv(1, 1'b0, 1'b0);
        chk("mid_rst_ack", rx_buf[0], 32'h4B);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_debug_controller.md
# mips_debug_controller

Sequencer between a byte-stream host link (UART rx/tx) and the `top_mips` debug ports. It decodes host commands to:
- load the instruction memory;
- pulse the CPU reset;
- run the CPU until halt, or single-step it;
- stream PC plus all 32 registers back to the host.

Only this block drives the CPU enable, the instruction-memory write port and the debug register-read address.

## Interface
- NB_DATA, 32, data/instruction width
- NB_ADDR, 32, instruction-memory address width (word index)
- NB_REG, 5, register address width
- NB_BYTE, 8, host byte width
- N_REGS, 32, registers dumped
- i_clk  in  1  clock; one clock domain
- i_reset  in  1  reset, synchronous, active-high
- i_rx_data  in  8  received host byte
- i_rx_valid  in  1  one-cycle strobe, i_rx_data valid; no backpressure
- i_tx_done  in  1  one-cycle strobe, transmitter finished current byte
- i_halt  in  1  CPU reached HALT
- i_pc  in  32  current CPU PC
- i_reg_data  in  32  register-file debug read data, valid 1 cycle after o_reg_addr
- o_tx_data  out  8  byte to transmit
- o_tx_start  out  1  one-cycle transmit request
- o_imem_write  out  1  one-cycle instruction-memory write strobe
- o_imem_addr  out  32  instruction-memory word index
- o_imem_data  out  32  instruction word
- o_cpu_enable  out  1  CPU pipeline advance enable
- o_cpu_reset  out  1  one-cycle CPU reset pulse
- o_reg_addr  out  5  debug register read address
- o_busy  out  1  high in every state except IDLE

## Operation
- Commands, accepted only in IDLE:
  - 0x4C 'L': load program.
  - 0x43 'C': CPU reset.
  - 0x52 'R': run.
  - 0x53 'S': step.
  - 0x44 'D': dump.
- Unknown bytes in IDLE are dropped. Bytes arriving in any other state except LOAD_CNT/LOAD_BYTE are dropped.
- States: IDLE, LOAD_CNT, LOAD_BYTE, LOAD_WR, ACK, CPU_RST, RUN, STEP, DUMP_LD, DUMP_RD, DUMP_TX, DUMP_WAIT.
- Load:
  - LOAD_CNT takes count N (0..255).
  - N=0 goes directly to ACK.
  - Otherwise LOAD_BYTE assembles 4 bytes MSB-first into a 32-bit word.
  - LOAD_WR pulses o_imem_write for 1 cycle, with o_imem_addr=k (k=0..N-1, counter zero-extended) and o_imem_data=word.
  - After word N-1 → ACK.
- ACK: transmit 0x4B 'K', wait i_tx_done → IDLE.
- CPU_RST: o_cpu_reset high exactly 1 cycle → ACK.
- RUN:
  - o_cpu_enable high from the cycle after 'R' is accepted.
  - If i_halt is sampled high at cycle t, o_cpu_enable is low from t+1, then → DUMP_LD.
  - If i_halt is already high when 'R' is accepted, there is no enable cycle → DUMP_LD.
- STEP: o_cpu_enable high exactly 1 cycle regardless of i_halt → DUMP_LD.
- Dump, 132 bytes total:
  - First i_pc (captured in DUMP_LD).
  - Then r0..r31: DUMP_LD sets o_reg_addr=r; DUMP_RD captures i_reg_data the next cycle.
  - Each 32-bit item is sent MSB-first: DUMP_TX pulses o_tx_start; DUMP_WAIT waits for i_tx_done.
  - After r31 byte 0 → IDLE.
- Tx handshake:
  - At most one byte outstanding.
  - i_tx_done is honoured only in the cycles after o_tx_start; a done coincident with start is ignored.
  - o_tx_data stays stable until done.

## Timing
- All outputs are registered.
- Reset values: o_tx_data=0, o_tx_start=0, o_imem_write=0, o_imem_addr=0, o_imem_data=0, o_cpu_enable=0, o_cpu_reset=0, o_reg_addr=0, o_busy=0; state IDLE; counters 0.
- i_reset mid-operation:
  - Aborts at the next edge to IDLE with the reset values above.
  - A partial load leaves the already-written words in memory.
  - No ack is sent.
- Command latency: command byte strobe at t → first action (enable, write or reset pulse) at t+1.
- Load: the o_imem_write for word k comes 1 cycle after the strobe of its 4th byte.
- Dump: o_reg_addr update to data capture is 1 cycle; capture to o_tx_start is 1 cycle.
- Word counter is 8 bits, byte counter is 2 bits, register counter is 6 bits (terminal at 32, no wrap into r0).

## Structure
- Shared package `mips_debug_pkg` holds:
  - the command byte constants (CMD_LOAD, CMD_RESET, CMD_RUN, CMD_STEP, CMD_DUMP, ACK_BYTE);
  - the state encoding;
  - DUMP_WORDS=33.
- Single module; the 32-bit to 4-byte MSB-first serializer is a natural sub-module `debug_word_tx`. It has a start/done handshake toward the FSM and drives o_tx_data/o_tx_start.

## Test plan
- Reset: hold i_reset 2 cycles mid-RUN → next cycle o_cpu_enable=0, o_busy=0, state IDLE.
- Load: 0x4C,0x02,00 22 10 20,00 00 00 00 → o_imem_write pulses with (addr 0, 0x00221020) then (addr 1, 0x00000000); then tx 0x4B.
- Step with host model holding PC=0x4, r2=0x6, others 0 → exactly one o_cpu_enable cycle. Tx stream is 00 00 00 04, 00×8, 00 00 00 06, then 00 bytes; 132 bytes total.
- Run: 'R' with i_halt asserted 10 cycles later → o_cpu_enable high exactly 10 cycles, then a 132-byte dump. 'R' with i_halt already high → 0 enable cycles, dump only.
- Protocol: unknown byte 0x7A and bytes during a dump → no outputs change. i_tx_done coincident with o_tx_start is ignored; the byte is not skipped.
- 'C' → o_cpu_reset high exactly 1 cycle, then ack 0x4B.
